// File: rtl/audio_sample_fetch_if.sv
// ROM read bus between the sample fetcher (master) and the sample ROM (slave).
// rom_data is valid a fixed number of cycles after a one-cycle rom_rd strobe.
interface audio_sample_fetch_if #(
  parameter int ADDR_W   = 17,
  parameter int SAMPLE_W = 16
);
  logic [ADDR_W-1:0]   rom_addr;
  logic                rom_rd;
  logic [SAMPLE_W-1:0] rom_data;

  modport master (
    output rom_addr,
    output rom_rd,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    output rom_data
  );
endinterface

// File: rtl/audio_sample_fetch.sv
// Follows the note address generator, fetches samples from ROM into a one-deep
// pending buffer and hands them to the codec on data_over. Define AUDIO_VOLUME_EN for the Volume gain port.
module audio_sample_fetch #(
  parameter int ADDR_W      = 17,
  parameter int SAMPLE_W    = 16,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_MAX    = 54831
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                INIT_FINISH,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic                data_over,
  input  logic                Mute,
`ifdef AUDIO_VOLUME_EN
  input  logic [3:0]          Volume,
`endif
  audio_sample_fetch_if.master rom,
  output logic [SAMPLE_W-1:0] LDATA,
  output logic [SAMPLE_W-1:0] RDATA,
  output logic                sample_valid,
  output logic [7:0]          underrun_cnt,
  output logic [7:0]          overrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [1:0]          lat_cnt;
  logic [SAMPLE_W-1:0] pending;
  logic                pending_full;
  logic [SAMPLE_W-1:0] out_sample;

  logic                addr_changed;
  logic                addr_silent;
  logic                addr_take;
  logic                pend_wr;
  logic [SAMPLE_W-1:0] pend_wr_data;
  logic                handover;
  logic [SAMPLE_W-1:0] scaled;

  assign addr_changed = (Addr != last_addr);
  assign addr_silent  = (Addr > ADDR_W'(ADDR_MAX));
  assign addr_take    = INIT_FINISH && (state == S_CHECK) && addr_changed;
  assign handover     = INIT_FINISH && data_over;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt    = state;
    pend_wr      = 1'b0;
    pend_wr_data = '0;
    case (state)
      S_IDLE: begin
        if (INIT_FINISH) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (addr_changed) begin
          if (addr_silent) pend_wr = 1'b1;
          else             state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 2'd0) begin
          pend_wr      = 1'b1;
          pend_wr_data = rom.rom_data;
          state_nxt    = S_CHECK;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Losing codec init aborts whatever is in flight.
    if (!INIT_FINISH) begin
      state_nxt = S_IDLE;
      pend_wr   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // The fetched address is latched when CHECK commits to a read, so the ROM
  // address, last_addr and the range test all refer to the same value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_addr  <= '1;
      fetch_addr <= '0;
      lat_cnt    <= '0;
    end else begin
      if (addr_take) begin
        last_addr <= Addr;
        if (!addr_silent) fetch_addr <= Addr;
      end
      if (state == S_FETCH)
        lat_cnt <= 2'(ROM_LATENCY - 1);
      else if (state == S_WAIT && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;
    end
  end

`ifdef AUDIO_VOLUME_EN
  logic signed [SAMPLE_W+5:0] samp_ext;
  logic signed [SAMPLE_W+5:0] gain_ext;

  // Gain (Volume+1)/16 never exceeds one, so the truncated result cannot overflow.
  always_comb begin
    samp_ext = {{6{pending[SAMPLE_W-1]}}, pending};
    gain_ext = {{(SAMPLE_W+1){1'b0}}, ({1'b0, Volume} + 5'd1)};
    scaled   = SAMPLE_W'((samp_ext * gain_ext) >>> 4);
  end
`else
  assign scaled = pending;
`endif

  // Handover reads the pre-edge pending value, so a same-cycle write simply
  // becomes the next pending sample without counting as an overrun.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the pending data word is reset along with its full flag; it is a
      // single register, not a RAM, so the reset costs nothing worth avoiding.
      pending      <= '0;
      pending_full <= 1'b0;
      out_sample   <= '0;
      sample_valid <= 1'b0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else if (!INIT_FINISH) begin
      pending      <= '0;
      pending_full <= 1'b0;
      out_sample   <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (handover) begin
        if (pending_full) begin
          out_sample   <= Mute ? '0 : scaled;
          sample_valid <= 1'b1;
        end else if (sample_valid && underrun_cnt != 8'hFF) begin
          underrun_cnt <= underrun_cnt + 8'd1;
        end
      end
      if (pend_wr) begin
        pending      <= pend_wr_data;
        pending_full <= 1'b1;
        if (pending_full && !handover && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end else if (handover) begin
        pending_full <= 1'b0;
      end
    end
  end

  assign rom.rom_rd   = (state == S_FETCH);
  assign rom.rom_addr = fetch_addr;
  assign LDATA        = out_sample;
  assign RDATA        = out_sample;

endmodule
